// File: rtl/sdram_posted_write_buffer_if.sv
// Bus bundle for the SDRAM posted-write buffer.
// The CPU side carries a single-cycle request strobe with ready, a write
// acknowledge pulse and a read-return pulse with data. The memory side
// carries the one-cycle mem_cs request, the head entry fields, and the
// controller's mem_ack completion with read data.
//   slave  : view used by the buffer itself
//   master : view used by the surrounding CPU/controller environment
interface sdram_posted_write_buffer_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 24
);
    // CPU side
    logic                   cpu_req;
    logic                   cpu_read0_write1;
    logic [ADDR_BITS-1:0]   cpu_addr;
    logic [DATA_BITS/8-1:0] cpu_byteenable;
    logic [DATA_BITS-1:0]   cpu_write_data;
    logic                   cpu_ready;
    logic                   cpu_write_ack;
    logic                   cpu_read_valid;
    logic [DATA_BITS-1:0]   cpu_read_data;
    logic                   buffer_empty;
    // Controller side
    logic                   mem_cs;
    logic                   mem_read0_write1;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [DATA_BITS/8-1:0] mem_byteenable;
    logic [DATA_BITS-1:0]   mem_write_data;
    logic                   mem_ack;
    logic [DATA_BITS-1:0]   mem_read_data;

    modport slave (
        input  cpu_req, cpu_read0_write1, cpu_addr, cpu_byteenable, cpu_write_data,
        output cpu_ready, cpu_write_ack, cpu_read_valid, cpu_read_data, buffer_empty,
        output mem_cs, mem_read0_write1, mem_addr, mem_byteenable, mem_write_data,
        input  mem_ack, mem_read_data
    );

    modport master (
        output cpu_req, cpu_read0_write1, cpu_addr, cpu_byteenable, cpu_write_data,
        input  cpu_ready, cpu_write_ack, cpu_read_valid, cpu_read_data, buffer_empty,
        input  mem_cs, mem_read0_write1, mem_addr, mem_byteenable, mem_write_data,
        output mem_ack, mem_read_data
    );
endinterface

// File: rtl/sdram_posted_write_buffer.sv
// Posted-write request buffer in front of the SDRAM controller.
// Requests are pushed into an in-order FIFO; writes are acknowledged one
// cycle after acceptance, reads block further admission until their data
// returns. A dispatcher issues the FIFO head to the controller one
// transaction at a time with a one-cycle mem_cs pulse and waits for mem_ack.
// Ports:
//   clk        : single clock
//   sync_reset : synchronous active-high reset
//   bus        : CPU and controller signals (slave view of the bundle)
module sdram_posted_write_buffer #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 24,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          sync_reset,
    sdram_posted_write_buffer_if.slave    bus
);
    localparam int BE_BITS = DATA_BITS / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 read_pending_q, read_pending_d;

    logic                 fifo_rw_q   [DEPTH];
    logic [ADDR_BITS-1:0] fifo_addr_q [DEPTH];
    logic [BE_BITS-1:0]   fifo_be_q   [DEPTH];
    logic [DATA_BITS-1:0] fifo_data_q [DEPTH];

    logic                 mem_cs_q;
    logic                 mem_rw_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [BE_BITS-1:0]   mem_be_q;
    logic [DATA_BITS-1:0] mem_data_q;
    logic                 cpu_write_ack_q;
    logic                 cpu_read_valid_q;
    logic [DATA_BITS-1:0] cpu_read_data_q;

    logic                 cpu_ready_s;
    logic                 push_s;
    logic                 pop_s;

    // Admission and pop qualification; mem_ack only counts while waiting.
    always_comb begin
        cpu_ready_s = (count_q < CNT_W'(DEPTH)) && !read_pending_q;
        push_s      = bus.cpu_req && cpu_ready_s;
        pop_s       = (state_q == S_WAIT_ACK) && bus.mem_ack;
    end

    // Next-state for occupancy, pointers and the outstanding-read flag.
    always_comb begin
        count_d        = count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        read_pending_d = read_pending_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // A read cannot be admitted while one is pending, so set and clear never collide.
        if (push_s && !bus.cpu_read0_write1) begin
            read_pending_d = 1'b1;
        end else if (pop_s && !mem_rw_q) begin
            read_pending_d = 1'b0;
        end else begin
            read_pending_d = read_pending_q;
        end
    end

    // FIFO storage: write accepted requests at the write pointer.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rw_q[i]   <= 1'b0;
                fifo_addr_q[i] <= '0;
                fifo_be_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_rw_q[wr_ptr_q]   <= bus.cpu_read0_write1;
            fifo_addr_q[wr_ptr_q] <= bus.cpu_addr;
            fifo_be_q[wr_ptr_q]   <= bus.cpu_byteenable;
            fifo_data_q[wr_ptr_q] <= bus.cpu_write_data;
        end
    end

    // Occupancy, pointer and outstanding-read registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            read_pending_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            read_pending_q <= read_pending_d;
        end
    end

    // Dispatcher FSM with registered controller fields and CPU pulses.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q          <= S_IDLE;
            mem_cs_q         <= 1'b0;
            mem_rw_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_be_q         <= '0;
            mem_data_q       <= '0;
            cpu_write_ack_q  <= 1'b0;
            cpu_read_valid_q <= 1'b0;
            cpu_read_data_q  <= '0;
        end else begin
            cpu_write_ack_q  <= push_s && bus.cpu_read0_write1;
            cpu_read_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // count_q excludes an entry pushed at this same edge, so a
                    // fresh write is issued one cycle after its acknowledge.
                    if (count_q != CNT_W'(0)) begin
                        mem_cs_q   <= 1'b1;
                        mem_rw_q   <= fifo_rw_q[rd_ptr_q];
                        mem_addr_q <= fifo_addr_q[rd_ptr_q];
                        mem_be_q   <= fifo_be_q[rd_ptr_q];
                        mem_data_q <= fifo_data_q[rd_ptr_q];
                        state_q    <= S_WAIT_ACK;
                    end else begin
                        mem_cs_q   <= 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    mem_cs_q <= 1'b0;
                    if (bus.mem_ack) begin
                        state_q <= S_IDLE;
                        if (!mem_rw_q) begin
                            cpu_read_data_q  <= bus.mem_read_data;
                            cpu_read_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_cs_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ready        = cpu_ready_s;
    assign bus.cpu_write_ack    = cpu_write_ack_q;
    assign bus.cpu_read_valid   = cpu_read_valid_q;
    assign bus.cpu_read_data    = cpu_read_data_q;
    assign bus.buffer_empty     = (count_q == CNT_W'(0)) && (state_q == S_IDLE);
    assign bus.mem_cs           = mem_cs_q;
    assign bus.mem_read0_write1 = mem_rw_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_byteenable   = mem_be_q;
    assign bus.mem_write_data   = mem_data_q;
endmodule

// File: tb/tb_sdram_posted_write_buffer.sv
module tb_sdram_posted_write_buffer;
    logic clk = 1'b0;
    logic sync_reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   acked = 0;
    int   rv_count = 0;
    logic [23:0] log_addr[$];
    logic        log_rw[$];

    sdram_posted_write_buffer_if #(.DATA_BITS(32), .ADDR_BITS(24)) bus();

    sdram_posted_write_buffer #(.DATA_BITS(32), .ADDR_BITS(24), .DEPTH(4)) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Record every controller request and read-return pulse.
    always @(negedge clk) begin
        if (bus.mem_cs) begin
            log_addr.push_back(bus.mem_addr);
            log_rw.push_back(bus.mem_read0_write1);
        end
        if (bus.cpu_read_valid) rv_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_rw.delete();
        acked = 0;
    endtask

    task automatic drive(input logic rw, input logic [23:0] a, input logic [31:0] d);
        bus.cpu_req          = 1'b1;
        bus.cpu_read0_write1 = rw;
        bus.cpu_addr         = a;
        bus.cpu_write_data   = d;
        bus.cpu_byteenable   = 4'hF;
    endtask

    // Acknowledge n controller requests, each delay cycles after it is seen.
    task automatic serve(input int n, input int delay, input logic [31:0] rdata);
        for (int k = 0; k < n; k++) begin
            int waited = 0;
            while (log_addr.size() <= acked && waited < 30) begin
                cycle();
                waited++;
            end
            checks++;
            if (log_addr.size() <= acked) begin
                errors++;
                $display("FAIL serve_timeout: mem_cs seen %0d times, required %0d", log_addr.size(), acked + 1);
            end
            repeat (delay) cycle();
            bus.mem_ack       = 1'b1;
            bus.mem_read_data = rdata;
            cycle();
            bus.mem_ack = 1'b0;
            acked++;
        end
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        repeat (2) cycle();
        sync_reset = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready); end
        checks++; if (bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.buffer_empty); end
        checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", bus.mem_cs); end
        checks++; if (bus.mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.cpu_write_ack !== 1'b0 || bus.cpu_read_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses: ack=%b rv=%b want 0 0", bus.cpu_write_ack, bus.cpu_read_valid); end
        checks++; if (bus.cpu_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_read_data); end
    endtask

    task automatic test_single_write();
        clear_log();
        drive(1'b1, 24'h000100, 32'hDEADBEEF);
        cycle();
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_write_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", bus.cpu_write_ack); end
        checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL single_cs_early: got %b want 0", bus.mem_cs); end
        checks++; if (bus.buffer_empty !== 1'b0) begin errors++; $display("FAIL single_notempty: got %b want 0", bus.buffer_empty); end
        cycle();
        checks++; if (bus.mem_cs !== 1'b1) begin errors++; $display("FAIL single_cs: got %b want 1", bus.mem_cs); end
        checks++; if (bus.mem_addr !== 24'h000100 || bus.mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fields: addr=%h data=%h want 000100 deadbeef", bus.mem_addr, bus.mem_write_data); end
        checks++; if (bus.mem_byteenable !== 4'hF || bus.mem_read0_write1 !== 1'b1) begin errors++; $display("FAIL single_be_rw: be=%h rw=%b want f 1", bus.mem_byteenable, bus.mem_read0_write1); end
        checks++; if (bus.cpu_write_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %b want 0", bus.cpu_write_ack); end
        cycle();
        checks++; if (bus.mem_cs !== 1'b0 || bus.mem_addr !== 24'h000100) begin errors++; $display("FAIL single_hold: cs=%b addr=%h want 0 000100", bus.mem_cs, bus.mem_addr); end
        serve(1, 4, 32'h0);
        checks++; if (bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b want 1", bus.buffer_empty); end
        repeat (3) cycle();
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL single_cs_count: got %0d want 1", log_addr.size()); end
    endtask

    task automatic test_fill();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            logic exp_ready;
            exp_ready = (i < 3) ? 1'b1 : 1'b0;
            drive(1'b1, 24'h10 + 24'(i), 32'hA0 + 32'(i));
            cycle();
            checks++; if (bus.cpu_write_ack !== 1'b1) begin errors++; $display("FAIL fill_ack%0d: got %b want 1", i, bus.cpu_write_ack); end
            checks++; if (bus.cpu_ready !== exp_ready) begin errors++; $display("FAIL fill_ready%0d: got %b want %b", i, bus.cpu_ready, exp_ready); end
        end
        drive(1'b1, 24'h14, 32'hA4);
        cycle();
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_write_ack !== 1'b0) begin errors++; $display("FAIL fill_fifth_ack: got %b want 0", bus.cpu_write_ack); end
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", bus.cpu_ready); end
        serve(4, 1, 32'h0);
        repeat (3) cycle();
        checks++; if (log_addr.size() !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++; if (log_addr[i] !== 24'h10 + 24'(i)) begin errors++; $display("FAIL fill_order%0d: got %h want %h", i, log_addr[i], 24'h10 + 24'(i)); end
        end
        checks++; if (bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", bus.buffer_empty); end
    endtask

    task automatic test_raw();
        int rv0;
        clear_log();
        rv0 = rv_count;
        drive(1'b1, 24'h20, 32'h12345678);
        cycle();
        drive(1'b0, 24'h20, 32'h0);
        cycle();
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_write_ack !== 1'b0) begin errors++; $display("FAIL raw_read_noack: got %b want 0", bus.cpu_write_ack); end
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL raw_ready_pending: got %b want 0", bus.cpu_ready); end
        serve(1, 3, 32'h0);
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL raw_read_early: mem_cs count %0d want 1", log_addr.size()); end
        serve(1, 2, 32'h12345678);
        checks++; if (bus.cpu_read_valid !== 1'b1) begin errors++; $display("FAIL raw_rvalid: got %b want 1", bus.cpu_read_valid); end
        checks++; if (bus.cpu_read_data !== 32'h12345678) begin errors++; $display("FAIL raw_rdata: got %h want 12345678", bus.cpu_read_data); end
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_after: got %b want 1", bus.cpu_ready); end
        cycle();
        checks++; if (bus.cpu_read_valid !== 1'b0 || bus.cpu_read_data !== 32'h12345678) begin errors++; $display("FAIL raw_pulse_hold: rv=%b data=%h want 0 12345678", bus.cpu_read_valid, bus.cpu_read_data); end
        checks++; if (log_rw.size() !== 2 || log_rw[0] !== 1'b1 || log_rw[1] !== 1'b0 || log_addr[1] !== 24'h20) begin errors++; $display("FAIL raw_sequence: n=%0d want write then read of 000020", log_rw.size()); end
        checks++; if (rv_count - rv0 !== 1) begin errors++; $display("FAIL raw_rv_count: got %0d want 1", rv_count - rv0); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        drive(1'b1, 24'h30, 32'hB0);
        cycle();
        drive(1'b1, 24'h31, 32'hB1);
        cycle();
        bus.cpu_req = 1'b0;
        cycle();
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL b2b_first_issue: got %0d want 1", log_addr.size()); end
        // count=2 here: pop and push land on the same edge
        bus.mem_ack = 1'b1;
        drive(1'b1, 24'h32, 32'hB2);
        cycle();
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        acked = 1;
        checks++; if (bus.cpu_write_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack: got %b want 1", bus.cpu_write_ack); end
        drive(1'b1, 24'h33, 32'hB3);
        cycle();
        checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready3: got %b want 1", bus.cpu_ready); end
        drive(1'b1, 24'h34, 32'hB4);
        cycle();
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready4: got %b want 0", bus.cpu_ready); end
        serve(4, 1, 32'h0);
        repeat (3) cycle();
        checks++; if (log_addr.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", log_addr.size()); end
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            checks++; if (log_addr[i] !== 24'h30 + 24'(i)) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", i, log_addr[i], 24'h30 + 24'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        int rv0;
        clear_log();
        drive(1'b1, 24'h40, 32'hC0);
        cycle();
        drive(1'b1, 24'h41, 32'hC1);
        cycle();
        drive(1'b0, 24'h42, 32'h0);
        cycle();
        bus.cpu_req = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b0 || bus.buffer_empty !== 1'b0) begin errors++; $display("FAIL mid_pre: ready=%b empty=%b want 0 0", bus.cpu_ready, bus.buffer_empty); end
        sync_reset = 1'b1;
        cycle();
        sync_reset = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b1 || bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL mid_ready_empty: ready=%b empty=%b want 1 1", bus.cpu_ready, bus.buffer_empty); end
        checks++; if (bus.mem_cs !== 1'b0 || bus.mem_addr !== 24'h0) begin errors++; $display("FAIL mid_mem: cs=%b addr=%h want 0 0", bus.mem_cs, bus.mem_addr); end
        checks++; if (bus.cpu_read_valid !== 1'b0 || bus.cpu_read_data !== 32'h0) begin errors++; $display("FAIL mid_read: rv=%b data=%h want 0 0", bus.cpu_read_valid, bus.cpu_read_data); end
        clear_log();
        rv0 = rv_count;
        bus.mem_ack       = 1'b1;
        bus.mem_read_data = 32'hBAD0BAD0;
        cycle();
        bus.mem_ack = 1'b0;
        repeat (4) cycle();
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL mid_stray_cs: got %0d want 0", log_addr.size()); end
        checks++; if (rv_count !== rv0) begin errors++; $display("FAIL mid_stray_rv: got %0d want %0d", rv_count, rv0); end
        checks++; if (bus.buffer_empty !== 1'b1 || bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_stray_state: empty=%b ready=%b want 1 1", bus.buffer_empty, bus.cpu_ready); end
    endtask

    initial begin
        bus.cpu_req          = 1'b0;
        bus.cpu_read0_write1 = 1'b0;
        bus.cpu_addr         = 24'h0;
        bus.cpu_byteenable   = 4'h0;
        bus.cpu_write_data   = 32'h0;
        bus.mem_ack          = 1'b0;
        bus.mem_read_data    = 32'h0;
        test_reset();
        test_single_write();
        test_fill();
        test_raw();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
